// File: rtl/main_memory.sv
// main_memory: word-addressed backing store on the common snooping bus.
// Write-backs are committed after WRITE_LAT cycles; reads are returned after
// READ_LAT cycles by requesting the bus from the arbiter and driving the data
// while the requesting cache keeps BusRd/BusRdX asserted.
module main_memory #(
   parameter int MEM_DEPTH = 1024,
   parameter int READ_LAT  = 4,
   parameter int WRITE_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Address_Com,
   inout  wire  [31:0] Data_Bus_Com,
   inout  wire         Data_in_Bus,
   input  logic        BusRd,
   input  logic        BusRdX,
   input  logic        Mem_wr,
   input  logic        Mem_oprn_abort,
   output logic        Mem_write_done,
   output logic        Mem_snoop_req,
   input  logic        Mem_snoop_gnt
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam logic [3:0] RD_LOAD = 4'(READ_LAT - 1);
   localparam logic [3:0] WR_LOAD = 4'(WRITE_LAT - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      RD_REQ   = 3'd2,
      RD_DRIVE = 3'd3,
      WR_WAIT  = 3'd4,
      WR_DONE  = 3'd5
   } state_t;

   state_t          state_r, state_s;
   logic [3:0]      cnt_r, cnt_s;
   logic [AW-1:0]   idx_r;
   logic [31:0]     wdata_r;
   logic [31:0]     rd_data_r;
   logic            write_done_r, write_done_s;
   logic            snoop_req_r, snoop_req_s;
   logic            drive_r, drive_s;
   logic            mem_we_s;
   logic            rd_load_s;
   logic            unused_addr_s;
   logic [31:0]     mem_r [MEM_DEPTH];

   // Address bits outside the word-index field are deliberately ignored (aliasing).
   assign unused_addr_s = ^{Address_Com[31:AW+2], Address_Com[1:0]};

   assign mem_we_s  = (state_r == WR_WAIT) && (cnt_r == 4'd0);
   assign rd_load_s = (state_r == RD_REQ) && Mem_snoop_gnt && !Mem_oprn_abort;

   // Next-state and latency-counter logic.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (Mem_wr) begin
               state_s = WR_WAIT;
               cnt_s   = WR_LOAD;
            end else if (BusRd || BusRdX) begin
               state_s = RD_WAIT;
               cnt_s   = RD_LOAD;
            end else begin
               state_s = IDLE;
               cnt_s   = 4'd0;
            end
         end
         RD_WAIT: begin
            if (Mem_oprn_abort) begin
               state_s = IDLE;
               cnt_s   = 4'd0;
            end else if (cnt_r == 4'd0) begin
               state_s = RD_REQ;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         RD_REQ: begin
            if (Mem_oprn_abort) begin
               state_s = IDLE;
            end else if (Mem_snoop_gnt) begin
               state_s = RD_DRIVE;
            end else begin
               state_s = RD_REQ;
            end
         end
         RD_DRIVE: begin
            // A late abort cannot cancel data already on the bus.
            if (!BusRd && !BusRdX) begin
               state_s = IDLE;
            end else begin
               state_s = RD_DRIVE;
            end
         end
         WR_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_s = WR_DONE;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         WR_DONE: begin
            if (!Mem_wr) begin
               state_s = IDLE;
            end else begin
               state_s = WR_DONE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state so they register cleanly.
   always_comb begin
      write_done_s = 1'b0;
      snoop_req_s  = 1'b0;
      drive_s      = 1'b0;
      case (state_s)
         RD_REQ: begin
            snoop_req_s = 1'b1;
         end
         RD_DRIVE: begin
            snoop_req_s = 1'b1;
            drive_s     = 1'b1;
         end
         WR_DONE: begin
            write_done_s = 1'b1;
         end
         default: begin
            write_done_s = 1'b0;
            snoop_req_s  = 1'b0;
            drive_s      = 1'b0;
         end
      endcase
   end

   // State, counter, captured request and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         idx_r        <= '0;
         wdata_r      <= 32'd0;
         write_done_r <= 1'b0;
         snoop_req_r  <= 1'b0;
         drive_r      <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         write_done_r <= write_done_s;
         snoop_req_r  <= snoop_req_s;
         drive_r      <= drive_s;
         if ((state_r == IDLE) && (Mem_wr || BusRd || BusRdX)) begin
            idx_r <= Address_Com[AW+1:2];
         end
         if ((state_r == IDLE) && Mem_wr) begin
            wdata_r <= Data_Bus_Com;
         end
      end
   end

   // Storage array (not reset) and read-data register loaded on grant.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[idx_r] <= wdata_r;
      end
      if (rd_load_s) begin
         rd_data_r <= mem_r[idx_r];
      end
   end

   assign Mem_write_done = write_done_r;
   assign Mem_snoop_req  = snoop_req_r;
   assign Data_Bus_Com   = drive_r ? rd_data_r : 32'bz;
   assign Data_in_Bus    = drive_r ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: randomized reads/writes against an associative-array
// memory model, plus directed latency, abort, alias/priority and reset scenarios.
module tb_main_memory;
   localparam int RL    = 4;
   localparam int WL    = 2;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr_com = 32'd0;
   logic        bus_rd = 1'b0, bus_rdx = 1'b0, mem_wr = 1'b0;
   logic        abort = 1'b0, gnt = 1'b0;
   logic        tb_oe = 1'b0;
   logic [31:0] tb_data = 32'd0;
   wire  [31:0] data_bus;
   wire         din_bus;
   logic        write_done, snoop_req;

   int total = 0;
   int bad   = 0;
   logic [31:0] mem_m [int];

   assign data_bus = tb_oe ? tb_data : 32'bz;

   main_memory #(.MEM_DEPTH(DEPTH), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
      .clk(clk), .rst_n(rst_n), .Address_Com(addr_com), .Data_Bus_Com(data_bus),
      .Data_in_Bus(din_bus), .BusRd(bus_rd), .BusRdX(bus_rdx), .Mem_wr(mem_wr),
      .Mem_oprn_abort(abort), .Mem_write_done(write_done),
      .Mem_snoop_req(snoop_req), .Mem_snoop_gnt(gnt)
   );

   always #5 clk = ~clk;

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic write_op(input logic [31:0] addr, input logic [31:0] data, input int hold);
      @(negedge clk);
      mem_wr = 1'b1; addr_com = addr; tb_oe = 1'b1; tb_data = data;
      for (int i = 0; i < WL; i++) begin
         @(negedge clk);
         addr_com = $urandom; tb_data = $urandom;
         total++;
         if (write_done !== 1'b0) begin bad++; $display("FAIL wr_early: done=%b want 0 cyc=%0d", write_done, i); end
      end
      @(negedge clk);
      total++;
      if (write_done !== 1'b1) begin bad++; $display("FAIL wr_done: done=%b want 1", write_done); end
      mem_m[widx(addr)] = data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         total++;
         if (write_done !== 1'b1) begin bad++; $display("FAIL wr_hold: done=%b want 1", write_done); end
      end
      mem_wr = 1'b0; tb_oe = 1'b0;
      @(negedge clk);
      total++;
      if (write_done !== 1'b0 || din_bus === 1'b1) begin
         bad++; $display("FAIL wr_clear: done=%b din=%b want 0/not-1", write_done, din_bus);
      end
   endtask

   task automatic read_op(input logic [31:0] addr, input bit use_rdx, input int gnt_dly,
                          input int hold, input bit poke_wr);
      logic [31:0] exp;
      exp = mem_m[widx(addr)];
      @(negedge clk);
      if (use_rdx) bus_rdx = 1'b1; else bus_rd = 1'b1;
      addr_com = addr;
      for (int i = 0; i < RL; i++) begin
         @(negedge clk);
         addr_com = $urandom;
         if (poke_wr && i == 0) begin mem_wr = 1'b1; tb_oe = 1'b1; tb_data = ~exp; end
         else begin mem_wr = 1'b0; tb_oe = 1'b0; end
         total++;
         if (snoop_req !== 1'b0 || din_bus === 1'b1 || write_done !== 1'b0) begin
            bad++; $display("FAIL rd_wait: req=%b din=%b done=%b want 0/not-1/0 cyc=%0d", snoop_req, din_bus, write_done, i);
         end
      end
      @(negedge clk);
      total++;
      if (snoop_req !== 1'b1) begin bad++; $display("FAIL rd_req: req=%b want 1", snoop_req); end
      for (int i = 0; i < gnt_dly; i++) begin
         @(negedge clk);
         total++;
         if (snoop_req !== 1'b1 || din_bus === 1'b1) begin
            bad++; $display("FAIL rd_req_hold: req=%b din=%b want 1/not-1", snoop_req, din_bus);
         end
      end
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      total++;
      if (snoop_req !== 1'b1 || din_bus !== 1'b1 || data_bus !== exp) begin
         bad++; $display("FAIL rd_drive: req=%b din=%b data=%h want 1/1/%h", snoop_req, din_bus, data_bus, exp);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         total++;
         if (din_bus !== 1'b1 || data_bus !== exp) begin
            bad++; $display("FAIL rd_hold: din=%b data=%h want 1/%h", din_bus, data_bus, exp);
         end
      end
      bus_rd = 1'b0; bus_rdx = 1'b0;
      @(negedge clk);
      total++;
      if (snoop_req !== 1'b0 || din_bus === 1'b1) begin
         bad++; $display("FAIL rd_release: req=%b din=%b want 0/not-1", snoop_req, din_bus);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (snoop_req !== 1'b0 || write_done !== 1'b0 || din_bus === 1'b1) begin
         bad++; $display("FAIL reset: req=%b done=%b din=%b want 0/0/not-1", snoop_req, write_done, din_bus);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      write_op(32'h0000_0100, 32'hCAFE_F00D, 1);
      read_op(32'h0000_0100, 1'b0, 1, 1, 1'b0);
   endtask

   task automatic test_abort();
      // abort sampled at capture+2 while in RD_WAIT
      @(negedge clk); bus_rdx = 1'b1; addr_com = 32'h0000_0100;
      @(negedge clk); bus_rdx = 1'b0;
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      for (int i = 0; i < RL + 3; i++) begin
         total++;
         if (snoop_req !== 1'b0 || din_bus === 1'b1) begin
            bad++; $display("FAIL abort_wait: req=%b din=%b want 0/not-1", snoop_req, din_bus);
         end
         @(negedge clk);
      end
      // abort while requesting the bus
      bus_rd = 1'b1; addr_com = 32'h0000_0100;
      repeat (RL + 1) @(negedge clk);
      total++;
      if (snoop_req !== 1'b1) begin bad++; $display("FAIL abort_req_pre: req=%b want 1", snoop_req); end
      abort = 1'b1; bus_rd = 1'b0;
      @(negedge clk); abort = 1'b0;
      total++;
      if (snoop_req !== 1'b0 || din_bus === 1'b1) begin
         bad++; $display("FAIL abort_req: req=%b din=%b want 0/not-1", snoop_req, din_bus);
      end
      // abort during drive is ignored
      @(negedge clk); bus_rd = 1'b1;
      repeat (RL + 1) @(negedge clk);
      gnt = 1'b1;
      @(negedge clk); gnt = 1'b0; abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      total++;
      if (snoop_req !== 1'b1 || din_bus !== 1'b1 || data_bus !== 32'hCAFE_F00D) begin
         bad++; $display("FAIL abort_drive: req=%b din=%b data=%h want 1/1/cafef00d", snoop_req, din_bus, data_bus);
      end
      bus_rd = 1'b0;
      @(negedge clk);
      total++;
      if (snoop_req !== 1'b0 || din_bus === 1'b1) begin
         bad++; $display("FAIL abort_drive_rel: req=%b din=%b want 0/not-1", snoop_req, din_bus);
      end
   endtask

   task automatic test_alias_priority();
      @(negedge clk);
      mem_wr = 1'b1; bus_rd = 1'b1; addr_com = 32'h0000_1100; tb_oe = 1'b1; tb_data = 32'h1234_5678;
      @(negedge clk);
      bus_rd = 1'b0; tb_data = 32'h0;
      @(negedge clk);
      total++;
      if (snoop_req !== 1'b0 || write_done !== 1'b0) begin
         bad++; $display("FAIL prio_wait: req=%b done=%b want 0/0", snoop_req, write_done);
      end
      @(negedge clk);
      total++;
      if (snoop_req !== 1'b0 || write_done !== 1'b1) begin
         bad++; $display("FAIL prio_done: req=%b done=%b want 0/1", snoop_req, write_done);
      end
      mem_m[widx(32'h0000_1100)] = 32'h1234_5678;
      mem_wr = 1'b0; tb_oe = 1'b0;
      @(negedge clk);
      total++;
      if (write_done !== 1'b0) begin bad++; $display("FAIL prio_clear: done=%b want 0", write_done); end
      read_op(32'h0000_0100, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      write_op(32'h0000_0200, 32'hAAAA_5555, 0);
      @(negedge clk);
      mem_wr = 1'b1; addr_com = 32'h0000_0200; tb_oe = 1'b1; tb_data = 32'hDEAD_BEEF;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (write_done !== 1'b0 || snoop_req !== 1'b0) begin
         bad++; $display("FAIL rstmid_async: done=%b req=%b want 0/0", write_done, snoop_req);
      end
      @(negedge clk); mem_wr = 1'b0; tb_oe = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < WL + 2; i++) begin
         @(negedge clk);
         total++;
         if (write_done !== 1'b0) begin bad++; $display("FAIL rstmid_done: done=%b want 0", write_done); end
      end
      read_op(32'h0000_0200, 1'b1, 0, 0, 1'b0);
      // reset while driving must release the bus at once
      @(negedge clk); bus_rd = 1'b1; addr_com = 32'h0000_0200;
      repeat (RL + 1) @(negedge clk);
      gnt = 1'b1;
      @(negedge clk); gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (snoop_req !== 1'b0 || din_bus === 1'b1) begin
         bad++; $display("FAIL rstmid_drive: req=%b din=%b want 0/not-1", snoop_req, din_bus);
      end
      bus_rd = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_random();
      int pool [8];
      for (int i = 0; i < 8; i++) pool[i] = int'($urandom_range(DEPTH - 1, 0));
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         logic [9:0]  ix;
         ix = 10'(pool[$urandom_range(7, 0)]);
         a = $urandom;
         a[11:2] = ix;
         if (!mem_m.exists(int'(ix)) || $urandom_range(1, 0) == 0)
            write_op(a, $urandom, int'($urandom_range(2, 0)));
         else
            read_op(a, 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
                    int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_abort();
      test_alias_priority();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 1024, giving the number of 32-bit words in the array (power of two).
REQ-002 The block SHALL have parameter READ_LAT, default 4, giving cycles from read capture to bus request (range 1..15).
REQ-003 The block SHALL have parameter WRITE_LAT, default 2, giving cycles from write capture to array update (range 1..15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Address_Com  input  32  common-bus address; word index = Address_Com[log2(MEM_DEPTH)+1:2].
REQ-007 Data_Bus_Com  inout  32  common-bus data; sampled on write, driven only in RD_DRIVE, else high-Z.
REQ-008 Data_in_Bus  inout  1  data-valid flag; driven 1 only in RD_DRIVE, else high-Z.
REQ-009 BusRd  input  1  cache read-miss request on common bus.
REQ-010 BusRdX  input  1  cache read-for-ownership request on common bus.
REQ-011 Mem_wr  input  1  cache write-back request; address/data valid while high.
REQ-012 Mem_oprn_abort  input  1  a snooping cache supplies the line; memory read cancelled.
REQ-013 Mem_write_done  output  1  write-back committed to array.
REQ-014 Mem_snoop_req  output  1  request to arbiter for bus ownership to return read data.
REQ-015 Mem_snoop_gnt  input  1  arbiter grant for Mem_snoop_req.

Function
REQ-016 The FSM SHALL have states IDLE, RD_WAIT, RD_REQ, RD_DRIVE, WR_WAIT, WR_DONE.
REQ-017 In IDLE, Mem_wr high SHALL capture address and Data_Bus_Com into registers and enter WR_WAIT, taking priority over a simultaneous BusRd/BusRdX.
REQ-018 In IDLE, BusRd or BusRdX high with Mem_wr low SHALL capture the address, load the latency counter, and enter RD_WAIT.
REQ-019 RD_WAIT SHALL count READ_LAT cycles; Mem_snoop_req SHALL go high at the READ_LAT-th edge after capture (state RD_REQ).
REQ-020 RD_REQ SHALL hold Mem_snoop_req high until Mem_snoop_gnt is sampled high, then enter RD_DRIVE on that edge.
REQ-021 RD_DRIVE SHALL drive Data_Bus_Com = array[captured index], Data_in_Bus = 1, and keep Mem_snoop_req high.
REQ-022 RD_DRIVE SHALL remain until both BusRd and BusRdX are sampled low, then release the bus (high-Z), drop Mem_snoop_req, and return to IDLE on that edge.
REQ-023 Mem_oprn_abort sampled high in RD_WAIT or RD_REQ SHALL return the FSM to IDLE on that edge with Mem_snoop_req low and no bus drive; in RD_DRIVE, the abort SHALL be ignored.
REQ-024 WR_WAIT SHALL count WRITE_LAT cycles; at the WRITE_LAT-th edge after capture, the array word SHALL be written with the captured data and Mem_write_done SHALL go high (state WR_DONE).
REQ-025 WR_DONE SHALL hold Mem_write_done high until Mem_wr is sampled low, then clear it and return to IDLE.
REQ-026 Address bits above the index field SHALL be ignored, so addresses alias modulo MEM_DEPTH words; bits [1:0] are ignored.
REQ-027 A read of a word SHALL return the value of the most recent completed write to that word.
REQ-028 Bus requests arriving in non-IDLE states SHALL be ignored; they are sampled again in the IDLE state.
REQ-029 The memory array SHALL NOT be cleared by reset; contents persist across rst_n.

Reset
REQ-030 While rst_n is low, the FSM SHALL be in IDLE, counters SHALL be 0, Mem_write_done = 0, Mem_snoop_req = 0, and Data_Bus_Com/Data_in_Bus SHALL be high-Z, all asynchronously.
REQ-031 Reset asserted mid-operation SHALL abandon it: a pending write not yet committed SHALL NOT update the array, and no bus drive may persist.
REQ-032 After rst_n deasserts, the first request SHALL be sampled at the first rising edge with rst_n high.

Verification
REQ-033 Write: Mem_wr=1, Address_Com=0x00000100, Data_Bus_Com=0xCAFEF00D -> Mem_write_done=1 two edges after capture and held until Mem_wr=0, then 0.
REQ-034 Read: BusRd=1 at 0x00000100, Mem_snoop_gnt given 1 cycle after req -> Mem_snoop_req at capture+4, Data_Bus_Com=0xCAFEF00D, Data_in_Bus=1 until BusRd=0, then high-Z.
REQ-035 Abort: BusRdX=1 at 0x00000100, Mem_oprn_abort=1 at capture+2 -> Mem_snoop_req never rises, bus stays high-Z, FSM in IDLE.
REQ-036 Alias and priority: Mem_wr (0x00001100, 0x12345678) together with BusRd -> write serviced first; a subsequent read of 0x00000100 returns 0x12345678.
REQ-037 Reset mid-write: rst_n=0 one cycle after Mem_wr capture at 0x00000200 (previously 0xAAAA5555) -> Mem_write_done stays 0; a later read returns 0xAAAA5555.
